// File: rtl/param_reg_file_pkg.sv
// Shared FunSel encodings and the next-value function used by the register
// cells and by the optional read bypass (PARAM_REG_FILE_BYPASS_EN).
package param_reg_file_pkg;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    // The function works on a fixed wide container; callers pass their real width.
    localparam int MAX_W = 64;

    typedef struct packed {
        logic [MAX_W-1:0] val;
        logic             wrap_up;
        logic             wrap_dn;
    } nv_t;

    function automatic nv_t next_val(input logic [MAX_W-1:0] cur,
                                     input logic [1:0]       funsel,
                                     input logic [MAX_W-1:0] din,
                                     input int               w);
        logic [MAX_W-1:0] mask;
        nv_t              r;
        mask      = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        r.val     = '0;
        r.wrap_up = 1'b0;
        r.wrap_dn = 1'b0;
        case (funsel)
            FS_DEC: begin
                r.val     = (cur - MAX_W'(1)) & mask;
                r.wrap_dn = ((cur & mask) == '0);
            end
            FS_INC: begin
                r.val     = (cur + MAX_W'(1)) & mask;
                r.wrap_up = ((cur & mask) == mask);
            end
            FS_LOAD: r.val = din & mask;
            default: r.val = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/param_reg_file_if.sv
// Control/data bundle of the register file: write controls, read selects,
// read data and sticky flags.
interface param_reg_file_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int SELW  = $clog2(DEPTH)
);
    logic [1:0]       FunSel;
    logic [DEPTH-1:0] RSel;
    logic [WIDTH-1:0] I;
    logic [SELW-1:0]  O1Sel;
    logic [SELW-1:0]  O2Sel;
    logic             FlagClr;
    logic [WIDTH-1:0] O1;
    logic [WIDTH-1:0] O2;
    logic [DEPTH-1:0] OvfFlags;
    logic [DEPTH-1:0] UdfFlags;

    modport master (
        output FunSel, RSel, I, O1Sel, O2Sel, FlagClr,
        input  O1, O2, OvfFlags, UdfFlags
    );

    modport slave (
        input  FunSel, RSel, I, O1Sel, O2Sel, FlagClr,
        output O1, O2, OvfFlags, UdfFlags
    );
endinterface

// File: rtl/param_reg_file_reg_cell.sv
// One register of the file with its sticky overflow/underflow flags.
module reg_cell
    import param_reg_file_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             sel,
    input  logic [1:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    input  logic             FlagClr,
    output logic [WIDTH-1:0] q,
    output logic             ovf,
    output logic             udf
);
    nv_t  nv;
    logic unused_nv;

    assign nv        = next_val(MAX_W'(q), FunSel, MAX_W'(I), WIDTH);
    assign unused_nv = ^nv.val;

    // A wrap in the same cycle as FlagClr leaves its flag set.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            q   <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (sel) q <= nv.val[WIDTH-1:0];
            ovf <= (ovf & ~FlagClr) | (sel & nv.wrap_up);
            udf <= (udf & ~FlagClr) | (sel & nv.wrap_dn);
        end
    end
endmodule

// File: rtl/param_reg_file.sv
// Parametrised register file: DEPTH cells, multi-select writes, two read ports.
// Define PARAM_REG_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
module param_reg_file
    import param_reg_file_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int SELW  = $clog2(DEPTH)
) (
    input logic             Clock,
    input logic             Reset,
    param_reg_file_if.slave bus
);
    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            ovf;
    logic [DEPTH-1:0]            udf;
    logic [1:0][SELW-1:0]        rd_idx;
    logic [1:0][WIDTH-1:0]       rd_data;

    genvar k, p;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_cell
            reg_cell #(.WIDTH(WIDTH)) u_cell (
                .Clock   (Clock),
                .Reset   (Reset),
                .sel     (bus.RSel[k]),
                .FunSel  (bus.FunSel),
                .I       (bus.I),
                .FlagClr (bus.FlagClr),
                .q       (regs[k]),
                .ovf     (ovf[k]),
                .udf     (udf[k])
            );
        end

        assign rd_idx = {bus.O2Sel, bus.O1Sel};

        for (p = 0; p < 2; p++) begin : g_rd
            logic             in_rng;
            logic [WIDTH-1:0] cur;
            assign in_rng = (32'(rd_idx[p]) < DEPTH);
            assign cur    = in_rng ? regs[rd_idx[p]] : '0;
`ifdef PARAM_REG_FILE_BYPASS_EN
            nv_t  nv;
            logic unused_nv;
            assign nv        = next_val(MAX_W'(cur), bus.FunSel, MAX_W'(bus.I), WIDTH);
            assign unused_nv = ^{nv.val, nv.wrap_up, nv.wrap_dn};
            // Forward only for a selected, existing register and never during reset.
            assign rd_data[p] = (Reset && in_rng && bus.RSel[rd_idx[p]]) ?
                                nv.val[WIDTH-1:0] : cur;
`else
            assign rd_data[p] = cur;
`endif
        end
    endgenerate

    assign bus.O1       = rd_data[0];
    assign bus.O2       = rd_data[1];
    assign bus.OvfFlags = ovf;
    assign bus.UdfFlags = udf;
endmodule

// File: tb/tb_param_reg_file.sv
// Randomized + directed bench for param_reg_file (WIDTH=8, DEPTH=8) against
// an array-based model; honours PARAM_REG_FILE_BYPASS_EN.
module tb_param_reg_file;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    param_reg_file_if #(.WIDTH(8), .DEPTH(8)) bus ();
    param_reg_file #(.WIDTH(8), .DEPTH(8)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [7:0] m [8];
    logic [7:0] movf = '0;
    logic [7:0] mudf = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mnext(input logic [7:0] v, input logic [1:0] fs,
                                         input logic [7:0] d);
        case (fs)
            2'd0:    return v - 8'd1;
            2'd1:    return v + 8'd1;
            2'd2:    return d;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] exp_rd(input logic [2:0] idx);
        logic [7:0] v;
        v = m[idx];
`ifdef PARAM_REG_FILE_BYPASS_EN
        if (Reset && bus.RSel[idx]) v = mnext(v, bus.FunSel, bus.I);
`endif
        return v;
    endfunction

    // Model update with the inputs that were stable across the edge.
    task automatic model_edge();
        if (!Reset) begin
            for (int k = 0; k < 8; k++) m[k] = 8'h00;
            movf = '0;
            mudf = '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                logic up, dn;
                up = bus.RSel[k] && bus.FunSel == 2'd1 && m[k] == 8'hFF;
                dn = bus.RSel[k] && bus.FunSel == 2'd0 && m[k] == 8'h00;
                movf[k] = (movf[k] && !bus.FlagClr) || up;
                mudf[k] = (mudf[k] && !bus.FlagClr) || dn;
                if (bus.RSel[k]) m[k] = mnext(m[k], bus.FunSel, bus.I);
            end
        end
    endtask

    task automatic cyc(input logic [1:0] fs, input logic [7:0] rs, input logic [7:0] d,
                       input logic [2:0] s1, input logic [2:0] s2,
                       input logic fc, input logic rst);
        bus.FunSel = fs; bus.RSel = rs; bus.I = d;
        bus.O1Sel = s1; bus.O2Sel = s2; bus.FlagClr = fc; Reset = rst;
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic peek(input logic [2:0] s1, input logic [2:0] s2);
        cyc(2'd0, 8'h00, 8'h00, s1, s2, 1'b0, 1'b1);
    endtask

    task automatic rand_cyc(input logic allow_rst);
        logic [7:0] d;
        case ($urandom_range(0, 2))
            0:       d = 8'h00;
            1:       d = 8'hFF;
            default: d = 8'($urandom);
        endcase
        cyc(2'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7)),
            d, 3'($urandom), 3'($urandom), $urandom_range(0, 7) == 0,
            !(allow_rst && $urandom_range(0, 49) == 0));
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("o1", 32'(bus.O1), 32'(exp_rd(bus.O1Sel)));
            chk("o2", 32'(bus.O2), 32'(exp_rd(bus.O2Sel)));
            chk("ovf", 32'(bus.OvfFlags), 32'(movf));
            chk("udf", 32'(bus.UdfFlags), 32'(mudf));
        end
    end

    initial begin
        for (int k = 0; k < 8; k++) m[k] = 8'h00;
        cyc(2'd0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc(2'd0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        chk_en = 1'b1;

        // Random activity, then a single reset edge.
        for (int n = 0; n < 20; n++) rand_cyc(1'b0);
        cyc(2'd1, 8'hFF, 8'h00, 3'd0, 3'd7, 1'b0, 1'b0);
        chk("rst_o1", 32'(bus.O1), 32'h00);
        chk("rst_o2", 32'(bus.O2), 32'h00);
        chk("rst_ovf", 32'(bus.OvfFlags), 32'h00);
        chk("rst_udf", 32'(bus.UdfFlags), 32'h00);

        cyc(2'd2, 8'h05, 8'hAA, 3'd0, 3'd2, 1'b0, 1'b1);
        peek(3'd0, 3'd2);
        chk("load_r0", 32'(bus.O1), 32'hAA);
        chk("load_r2", 32'(bus.O2), 32'hAA);
        peek(3'd1, 3'd2);
        chk("load_r1", 32'(bus.O1), 32'h00);

        cyc(2'd2, 8'h08, 8'hFF, 3'd3, 3'd3, 1'b0, 1'b1);
        cyc(2'd1, 8'h08, 8'h00, 3'd3, 3'd3, 1'b0, 1'b1);
        peek(3'd3, 3'd3);
        chk("inc_wrap", 32'(bus.O1), 32'h00);
        chk("inc_ovf", 32'(bus.OvfFlags), 32'h08);
        cyc(2'd1, 8'h08, 8'h00, 3'd3, 3'd3, 1'b0, 1'b1);
        peek(3'd3, 3'd3);
        chk("inc_again", 32'(bus.O1), 32'h01);
        chk("ovf_sticky", 32'(bus.OvfFlags), 32'h08);

        cyc(2'd3, 8'h01, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1);
        cyc(2'd0, 8'h01, 8'h00, 3'd0, 3'd0, 1'b1, 1'b1);
        peek(3'd0, 3'd0);
        chk("dec_wrap", 32'(bus.O1), 32'hFF);
        chk("dec_udf", 32'(bus.UdfFlags), 32'h01);
        chk("clr_ovf", 32'(bus.OvfFlags), 32'h00);

        cyc(2'd2, 8'hFF, 8'h12, 3'd0, 3'd0, 1'b0, 1'b1);
        cyc(2'd3, 8'hFF, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            peek(3'(2 * j), 3'(2 * j + 1));
            chk("clr_all_o1", 32'(bus.O1), 32'h00);
            chk("clr_all_o2", 32'(bus.O2), 32'h00);
        end
        chk("clr_keeps_udf", 32'(bus.UdfFlags), 32'h01);
        cyc(2'd2, 8'h00, 8'h55, 3'd4, 3'd5, 1'b0, 1'b1);
        peek(3'd4, 3'd5);
        chk("hold_o1", 32'(bus.O1), 32'h00);
        chk("hold_o2", 32'(bus.O2), 32'h00);

        // Same-cycle read of a register being loaded.
        bus.FunSel = 2'd2; bus.RSel = 8'h10; bus.I = 8'h3C;
        bus.O1Sel = 3'd4; bus.O2Sel = 3'd0; bus.FlagClr = 1'b0; Reset = 1'b1;
        #1;
`ifdef PARAM_REG_FILE_BYPASS_EN
        chk("bypass_pre", 32'(bus.O1), 32'h3C);
`else
        chk("bypass_pre", 32'(bus.O1), 32'h00);
`endif
        @(posedge Clock);
        model_edge();
        #1;
        peek(3'd4, 3'd0);
        chk("bypass_post", 32'(bus.O1), 32'h3C);

        for (int n = 0; n < 400; n++) rand_cyc(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/param_reg_file.md
Name: param_reg_file

Overview:
- Parametrised general-purpose register file; next generation of the fixed 8-bit, 4-entry RegFile.
- Provides WIDTH-bit registers, DEPTH entries, and a multi-select write mask.
- Each entry has sticky wrap-around (overflow/underflow) flags for increment/decrement.
- Two combinational read ports feed the ALU operand muxes in ALU_System.

Parameters:
- WIDTH, 8, bit width of each register.
- DEPTH, 8, number of registers; any value 2..16.
- SELW, $clog2(DEPTH), read-select width (derived; do not override).

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- FunSel  in  2  operation applied to selected registers
- RSel  in  DEPTH  write-select mask; bit k selects register k; multiple bits allowed
- I  in  WIDTH  load data
- O1Sel  in  SELW  read port 1 register index
- O2Sel  in  SELW  read port 2 register index
- FlagClr  in  1  clears all sticky flags
- O1  out  WIDTH  read port 1 data
- O2  out  WIDTH  read port 2 data
- OvfFlags  out  DEPTH  sticky: register k incremented from all-ones
- UdfFlags  out  DEPTH  sticky: register k decremented from zero

Behaviour:
- Reset (Reset==0 at rising Clock) forces:
  - all registers = 0;
  - OvfFlags = 0 and UdfFlags = 0;
  - hence O1 = O2 = 0.
  - Reset has priority over every other input, including mid-sequence.
- FunSel encoding, applied at rising Clock to every register whose RSel bit is 1:
  - 00 decrement (mod 2^WIDTH);
  - 01 increment (mod 2^WIDTH);
  - 10 load I;
  - 11 clear to 0.
- RSel == 0: no register changes (hold); FunSel is ignored.
- Arithmetic: wrap-around, no saturation.
  - 0 - 1 = all-ones; all-ones + 1 = 0.
- Flag set rules:
  - increment of a selected register holding all-ones sets OvfFlags[k];
  - decrement of a selected register holding 0 sets UdfFlags[k];
  - flags stay set until FlagClr or Reset.
- FlagClr==1 clears all flags at the next edge.
  - If a wrap event occurs in the same cycle, the flag for that register is set (set wins).
  - All other flags are cleared.
- Load and clear never affect flags.
- Reads: O1 = reg[O1Sel], O2 = reg[O2Sel], combinational, zero latency, reflecting state after the last edge.
  - O1Sel == O2Sel is legal; both outputs show the same value.
  - An index >= DEPTH (non-power-of-2 DEPTH) returns 0.
- Write-then-read: without the optional feature, a write at edge n is visible on O1/O2 after edge n.
- Unselected registers and flags hold their value every cycle.

Optional Feature:
- Macro: PARAM_REG_FILE_BYPASS_EN.
- Defined: O1/O2 forward the next-state value when the read index is selected by RSel this cycle (value computed from FunSel/I/current reg).
  - Read-after-write latency becomes 0.
  - Bypass is suppressed while Reset==0; outputs then show the current register.
- Undefined: plain register read as above. No bypass logic is synthesised.

Decomposition:
- Package param_reg_file_pkg holds:
  - FunSel localparams FS_DEC=2'b00, FS_INC=2'b01, FS_LOAD=2'b10, FS_CLR=2'b11;
  - a function next_val(cur, funsel, din) returning value plus wrap-up and wrap-down bits, shared with the bypass path.
- Sub-module reg_cell: one WIDTH-bit register with its Ovf/Udf flag bits.
  - Inputs: Clock, Reset, sel, FunSel, I, FlagClr.
  - param_reg_file generates DEPTH instances and the two read muxes.

Test Plan (WIDTH=8, DEPTH=8):
- Reset low one edge after random activity -> O1=O2=0x00, OvfFlags=UdfFlags=0x00.
- FunSel=10, RSel=0x05, I=0xAA; then O1Sel=0, O2Sel=2 -> O1=O2=0xAA; O1Sel=1 -> 0x00.
- Load 0xFF into R3, then FunSel=01, RSel=0x08 -> R3=0x00, OvfFlags=0x08; next increment -> R3=0x01, OvfFlags still 0x08.
- R0=0x00, FunSel=00, RSel=0x01 with FlagClr=1 in the same cycle, OvfFlags=0x08 beforehand -> R0=0xFF, UdfFlags=0x01, OvfFlags=0x00.
- FunSel=11, RSel=0xFF after loads -> all reads 0x00, flags unchanged; RSel=0x00 with FunSel=10, I=0x55 -> no change.
- Bypass defined: FunSel=10, RSel=0x10, I=0x3C, O1Sel=4 before the edge -> O1=0x3C combinationally; undefined -> O1=0x3C only after the edge.
